rr_request_arbiter_8: RTL and testbench

- Upstream stage of the 8-to-3 encoder path. Captures single-cycle request pulses from 8 sources into sticky pending bits.
- Picks one pending source per transaction using round-robin priority.
- Presents the winner as a registered one-hot grant with valid/ready handshake. Grant is guaranteed one-hot whenever valid, so the downstream encoder never sees its all-zero/multi-hot default case.

---
 rtl/arb_pkg.sv | 10 +
 rtl/rr_pick_onehot.sv | 19 +
 rtl/rr_request_arbiter_8.sv | 67 ++++++
 tb/tb_rr_request_arbiter_8.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared constants, FSM state type and one-hot index helper for the arbiter/encoder path.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int PTR_W = $clog2(N_REQ);
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] v);
    onehot_to_idx = '0;
    for (int i = 0; i < N_REQ; i++) onehot_to_idx |= v[i] ? PTR_W'(i) : '0;
  endfunction
endpackage

// File: rtl/rr_pick_onehot.sv
// rr_pick_onehot: round-robin pick of the first set candidate at or above ptr, wrapping.
module rr_pick_onehot #(
  parameter int N = 8,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_cand,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_winner,
  output logic             o_any
);
  logic [N-1:0] w_rot, w_low;
  // Rotate ptr down to bit 0, isolate lowest set bit, rotate back.
  always_comb begin
    w_rot = N'({i_cand, i_cand} >> i_ptr);
    w_low = w_rot & (~w_rot + N'(1));
    o_winner = N'(({w_low, w_low} << i_ptr) >> N);
    o_any = |i_cand;
  end
endmodule

// File: rtl/rr_request_arbiter_8.sv
// rr_request_arbiter_8: sticky request capture with round-robin one-hot grant and valid/ready handshake.
module rr_request_arbiter_8 #(
  parameter int N = arb_pkg::N_REQ,
  localparam int PTR_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic         flush,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  input  logic         grant_ready,
  output logic [N-1:0] pending
);
  import arb_pkg::*;
  state_t           r_state, w_state_nxt;
  logic [N-1:0]     r_grant, r_pending, w_grant_nxt, w_pending_nxt, w_acc, w_cand, w_win;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt, w_idx;
  logic             w_any;
  assign grant = r_grant;
  assign grant_valid = r_state == GRANT;
  assign pending = r_pending;
  assign w_acc = (grant_valid && grant_ready) ? r_grant : '0;
  assign w_cand = (r_pending | req_in) & ~w_acc;
  rr_pick_onehot #(.N(N)) u_pick (
    .i_cand(w_cand),
    .i_ptr(r_ptr),
    .o_winner(w_win),
    .o_any(w_any)
  );
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N; i++) if (r_grant[i]) w_idx = PTR_W'(i);
  end
  // Flush outranks accept; set outranks clear on the same pending bit.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt = r_ptr;
    w_pending_nxt = (r_pending & ~w_acc) | req_in;
    if (flush) begin
      w_state_nxt = IDLE;
      w_grant_nxt = '0;
      w_pending_nxt = '0;
    end else if (r_state == IDLE) begin
      w_state_nxt = w_any ? GRANT : IDLE;
      w_grant_nxt = w_any ? w_win : '0;
    end else if (grant_ready) begin
      w_ptr_nxt = (w_idx == PTR_W'(N - 1)) ? '0 : w_idx + PTR_W'(1);
      w_state_nxt = w_any ? GRANT : IDLE;
      w_grant_nxt = w_any ? w_win : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_pending <= '0;
      r_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_pending <= w_pending_nxt;
      r_ptr <= w_ptr_nxt;
    end
  end
endmodule

// File: tb/tb_rr_request_arbiter_8.sv
// tb_rr_request_arbiter_8: directed scoreboard bench plus randomized invariant checks.
module tb_rr_request_arbiter_8;
  import arb_pkg::*;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, grant_ready = 1'b0, grant_valid;
  logic [7:0] req_in = '0, grant, pending;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  bit sb_on = 1'b1;
  always #5 clk = ~clk;
  rr_request_arbiter_8 dut (
    .clk(clk),
    .rst(rst),
    .req_in(req_in),
    .flush(flush),
    .grant(grant),
    .grant_valid(grant_valid),
    .grant_ready(grant_ready),
    .pending(pending)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] ref_idx(input logic [7:0] v);
    ref_idx = 0;
    for (int i = 0; i < 8; i++) if (v[i]) ref_idx = i;
  endfunction
  always @(negedge clk) begin
    if (!rst) begin
      if (grant_valid) begin
        chk("onehot", {31'b0, $onehot(grant)}, 1);
        chk("subset", {24'b0, grant & ~pending}, 0);
        chk("enc_idx", {29'b0, onehot_to_idx(grant)}, ref_idx(grant));
      end else chk("idle_zero", {24'b0, grant}, 0);
      if (sb_on && grant_valid && grant_ready && !flush) begin
        if (exp_q.size() == 0) chk("sb_unexpected", {24'b0, grant}, 32'hffff_ffff);
        else chk("sb_grant", {24'b0, grant}, {24'b0, exp_q.pop_front()});
      end
    end
  end
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_grant", {24'b0, grant}, 0);
    chk("rst_valid", {31'b0, grant_valid}, 0);
    chk("rst_pending", {24'b0, pending}, 0);
    // single request
    req_in = 8'h04;
    tick();
    req_in = 8'h00;
    chk("single_grant", {24'b0, grant}, 8'h04);
    chk("single_valid", {31'b0, grant_valid}, 1);
    chk("single_pend", {24'b0, pending}, 8'h04);
    exp_q.push_back(8'h04);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    chk("single_done_pend", {24'b0, pending}, 0);
    chk("single_done_valid", {31'b0, grant_valid}, 0);
    chk("single_ptr", {29'b0, dut.r_ptr}, 3);
    // round robin from reset pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_ptr", {29'b0, dut.r_ptr}, 0);
    req_in = 8'hFF;
    grant_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h01 << i);
    tick();
    req_in = 8'h00;
    repeat (8) tick();
    chk("rr_valid", {31'b0, grant_valid}, 0);
    chk("rr_pend", {24'b0, pending}, 0);
    chk("rr_ptr_wrap", {29'b0, dut.r_ptr}, 0);
    // backpressure
    grant_ready = 1'b0;
    req_in = 8'h81;
    tick();
    for (int i = 0; i < 5; i++) begin
      req_in = (i == 1) ? 8'h10 : 8'h00;
      tick();
      chk("bp_hold", {24'b0, grant}, 8'h01);
      chk("bp_valid", {31'b0, grant_valid}, 1);
    end
    chk("bp_pend", {24'b0, pending}, 8'h91);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h80);
    grant_ready = 1'b1;
    repeat (3) tick();
    grant_ready = 1'b0;
    chk("bp_done_valid", {31'b0, grant_valid}, 0);
    chk("bp_ptr", {29'b0, dut.r_ptr}, 0);
    // set/clear collision
    req_in = 8'h08;
    tick();
    chk("col_grant", {24'b0, grant}, 8'h08);
    exp_q.push_back(8'h08);
    grant_ready = 1'b1;
    tick();
    req_in = 8'h00;
    grant_ready = 1'b0;
    chk("col_valid", {31'b0, grant_valid}, 0);
    chk("col_pend", {24'b0, pending}, 8'h08);
    exp_q.push_back(8'h08);
    tick();
    chk("col_regrant", {24'b0, grant}, 8'h08);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    chk("col_done_pend", {24'b0, pending}, 0);
    chk("col_ptr", {29'b0, dut.r_ptr}, 4);
    // flush beats accept and discards req_in
    req_in = 8'h3C;
    tick();
    chk("fl_grant", {24'b0, grant}, 8'h10);
    chk("fl_pend", {24'b0, pending}, 8'h3C);
    req_in = 8'h01;
    flush = 1'b1;
    grant_ready = 1'b1;
    tick();
    flush = 1'b0;
    grant_ready = 1'b0;
    req_in = 8'h00;
    chk("fl_pend0", {24'b0, pending}, 0);
    chk("fl_grant0", {24'b0, grant}, 0);
    chk("fl_valid0", {31'b0, grant_valid}, 0);
    chk("fl_ptr_kept", {29'b0, dut.r_ptr}, 4);
    // mid-run reset
    req_in = 8'h3C;
    tick();
    req_in = 8'h00;
    chk("mr_grant", {24'b0, grant}, 8'h10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_grant0", {24'b0, grant}, 0);
    chk("mr_valid0", {31'b0, grant_valid}, 0);
    chk("mr_pend0", {24'b0, pending}, 0);
    chk("mr_ptr0", {29'b0, dut.r_ptr}, 0);
    chk("sb_empty", exp_q.size(), 0);
    // random traffic: invariants only
    sb_on = 1'b0;
    repeat (10000) begin
      req_in = 8'($urandom);
      grant_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 15) == 0);
      tick();
    end
    req_in = 8'h00;
    flush = 1'b0;
    grant_ready = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
